// File: rtl/pflink_crc16_checker.sv
// Receive-side CRC-16 checker for pflink frames: recomputes the CRC over the masked
// payload words, compares it with the trailer and keeps saturating good/bad counters.
module pflink_crc16_checker #(
    parameter logic [15:0] INIT_CRC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      data,
    input  logic             valid,
    input  logic [1:0]       we,
    input  logic             sof,
    input  logic             eof,
    input  logic             clear_counters,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             framing_err,
    output logic [15:0]      crc_calc,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        crc_q, crc_d;
    logic               crc_ok_q, crc_ok_d;
    logic               crc_err_q, crc_err_d;
    logic               framing_err_q, framing_err_d;
    logic [15:0]        crc_calc_q, crc_calc_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   bad_q, bad_d;

    logic [31:0]        maskedWord;
    logic               goodInc;
    logic [1:0]         badInc;
    logic               abortFrame;
    logic [CNT_W:0]     goodSum;
    logic [CNT_W:0]     badSum;
    logic [CNT_W:0]     badIncExt;

    // MSB-first CRC-16 (x^16+x^12+x^5+1), one full 32-bit word per call.
    function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [31:0] word);
        logic [15:0] c;
        c = crcIn;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ word[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign maskedWord = {we[1] ? data[31:16] : 16'h0000, we[0] ? data[15:0] : 16'h0000};
    assign abortFrame = valid && sof && (state_q == PAYLOAD);

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        crc_ok_d      = 1'b0;
        crc_err_d     = 1'b0;
        framing_err_d = 1'b0;
        crc_calc_d    = crc_calc_q;
        goodInc       = 1'b0;
        badInc        = 2'd0;

        if (valid) begin
            if ((state_q == PAYLOAD) && !sof) begin
                if (eof) begin
                    crc_calc_d = crc_q;
                    crc_d      = INIT_CRC;
                    state_d    = IDLE;
                    if (data[15:0] == crc_q) begin
                        crc_ok_d = 1'b1;
                        goodInc  = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                        badInc    = 2'd1;
                    end
                end else begin
                    crc_d = crcStep(crc_q, maskedWord);
                end
            end else begin
                // An aborted frame is charged first; the same word then opens the next frame.
                if (abortFrame) begin
                    framing_err_d = 1'b1;
                    crc_err_d     = 1'b1;
                    badInc        = 2'd1;
                end
                if (!sof) begin
                    framing_err_d = 1'b1;
                end else if (eof) begin
                    crc_calc_d = INIT_CRC;
                    crc_d      = INIT_CRC;
                    state_d    = IDLE;
                    if (data[15:0] == INIT_CRC) begin
                        crc_ok_d = !abortFrame;
                        goodInc  = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                        badInc    = badInc + 2'd1;
                    end
                end else begin
                    crc_d   = crcStep(INIT_CRC, maskedWord);
                    state_d = PAYLOAD;
                end
            end
        end

        badIncExt      = '0;
        badIncExt[1:0] = badInc;
        goodSum        = {1'b0, good_q} + {{CNT_W{1'b0}}, goodInc};
        badSum         = {1'b0, bad_q} + badIncExt;

        if (clear_counters) begin
            good_d = '0;
            bad_d  = '0;
        end else begin
            good_d = goodSum[CNT_W] ? {CNT_W{1'b1}} : goodSum[CNT_W-1:0];
            bad_d  = badSum[CNT_W]  ? {CNT_W{1'b1}} : badSum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            crc_q         <= INIT_CRC;
            crc_ok_q      <= 1'b0;
            crc_err_q     <= 1'b0;
            framing_err_q <= 1'b0;
            crc_calc_q    <= 16'h0000;
            good_q        <= '0;
            bad_q         <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            crc_ok_q      <= crc_ok_d;
            crc_err_q     <= crc_err_d;
            framing_err_q <= framing_err_d;
            crc_calc_q    <= crc_calc_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
        end
    end

    assign crc_ok      = crc_ok_q;
    assign crc_err     = crc_err_q;
    assign framing_err = framing_err_q;
    assign crc_calc    = crc_calc_q;
    assign good_count  = good_q;
    assign bad_count   = bad_q;

endmodule

// File: tb/tb_pflink_crc16_checker.sv
// Directed bench for pflink_crc16_checker: a frame-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pflink_crc16_checker;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [15:0] INIT = 16'h0000;

    logic             clk;
    logic             reset_n;
    logic [31:0]      data;
    logic             valid;
    logic [1:0]       we;
    logic             sof;
    logic             eof;
    logic             clear_counters;
    logic             crc_ok;
    logic             crc_err;
    logic             framing_err;
    logic [15:0]      crc_calc;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] bad_count;

    int compared = 0;
    int mismatched = 0;

    pflink_crc16_checker #(
        .INIT_CRC(INIT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .data(data),
        .valid(valid),
        .we(we),
        .sof(sof),
        .eof(eof),
        .clear_counters(clear_counters),
        .crc_ok(crc_ok),
        .crc_err(crc_err),
        .framing_err(framing_err),
        .crc_calc(crc_calc),
        .good_count(good_count),
        .bad_count(bad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: payload words of the open frame and the expected registered outputs.
    bit          mInFrame;
    logic [31:0] mFrame[$];
    bit          eOk, eErr, eFe;
    logic [15:0] eCalc;
    int          eGood, eBad;

    // Remainder of a 48-bit polynomial modulo x^16+x^12+x^5+1.
    function automatic logic [15:0] polyMod48(input logic [47:0] v);
        logic [47:0] r;
        r = v;
        for (int i = 47; i >= 16; i--) begin
            if (r[i]) r = r ^ (48'h11021 << (i - 16));
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] crcOfFrame();
        logic [15:0] r;
        r = INIT;
        foreach (mFrame[k]) r = polyMod48({r, 32'h0} ^ {16'h0, mFrame[k], 16'h0});
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [1:0] w,
                                 input logic [31:0] d, input bit clr);
        @(negedge clk);
        valid = v;
        sof = s;
        eof = e;
        we = w;
        data = d;
        clear_counters = clr;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    endtask

    // Model update on each active edge, comparison shortly after it.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                mInFrame = 0;
                mFrame.delete();
                eOk = 0; eErr = 0; eFe = 0;
                eCalc = 16'h0;
                eGood = 0; eBad = 0;
            end else begin
                int gInc, bInc;
                bit aborted;
                logic [15:0] c;
                logic [31:0] mw;
                gInc = 0; bInc = 0; aborted = 0;
                eOk = 0; eErr = 0; eFe = 0;
                mw = {we[1] ? data[31:16] : 16'h0, we[0] ? data[15:0] : 16'h0};
                if (valid) begin
                    if (mInFrame && !sof) begin
                        if (eof) begin
                            c = crcOfFrame();
                            eCalc = c;
                            if (data[15:0] == c) begin eOk = 1; gInc = 1; end
                            else begin eErr = 1; bInc = 1; end
                            mInFrame = 0;
                            mFrame.delete();
                        end else begin
                            mFrame.push_back(mw);
                        end
                    end else begin
                        if (mInFrame) begin
                            aborted = 1; eFe = 1; eErr = 1; bInc = 1;
                            mInFrame = 0;
                            mFrame.delete();
                        end
                        if (!sof) begin
                            eFe = 1;
                        end else if (eof) begin
                            eCalc = INIT;
                            if (data[15:0] == INIT) begin gInc++; eOk = !aborted; end
                            else begin bInc++; eErr = 1; end
                        end else begin
                            mFrame.push_back(mw);
                            mInFrame = 1;
                        end
                    end
                end
                if (clear_counters) begin
                    eGood = 0; eBad = 0;
                end else begin
                    eGood = (eGood + gInc > CNT_MAX) ? CNT_MAX : eGood + gInc;
                    eBad  = (eBad + bInc > CNT_MAX) ? CNT_MAX : eBad + bInc;
                end
            end
            #1;
            checkOutput("model crc_ok", 32'(crc_ok), 32'(eOk));
            checkOutput("model crc_err", 32'(crc_err), 32'(eErr));
            checkOutput("model framing_err", 32'(framing_err), 32'(eFe));
            checkOutput("model crc_calc", 32'(crc_calc), 32'(eCalc));
            checkOutput("model good_count", 32'(good_count), 32'(eGood));
            checkOutput("model bad_count", 32'(bad_count), 32'(eBad));
        end
    end

    initial begin
        reset_n = 1'b0;
        valid = 0; sof = 0; eof = 0; we = 2'b00; data = 32'h0; clear_counters = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset crc_ok", 32'(crc_ok), 32'h0);
        checkOutput("reset crc_calc", 32'(crc_calc), 32'h0);
        checkOutput("reset good_count", 32'(good_count), 32'h0);
        checkOutput("reset bad_count", 32'(bad_count), 32'h0);
        reset_n = 1'b1;

        // Empty frame
        applyStimulus(1, 1, 1, 2'b11, 32'h0000_0000, 0);
        idleCycle();
        checkOutput("empty crc_ok", 32'(crc_ok), 32'h1);
        checkOutput("empty good_count", 32'(good_count), 32'h1);
        checkOutput("empty crc_calc", 32'(crc_calc), 32'h0);

        // Single payload word, good then bad trailer
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        applyStimulus(1, 0, 1, 2'b00, 32'h0000_1021, 0);
        idleCycle();
        checkOutput("single crc_ok", 32'(crc_ok), 32'h1);
        checkOutput("single crc_calc", 32'(crc_calc), 32'h1021);
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_1020, 0);
        idleCycle();
        checkOutput("single bad crc_err", 32'(crc_err), 32'h1);
        checkOutput("single bad bad_count", 32'(bad_count), 32'h1);

        // Lane 0 masked away
        applyStimulus(1, 1, 0, 2'b10, 32'h0000_0001, 0);
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_0000, 0);
        idleCycle();
        checkOutput("mask crc_ok", 32'(crc_ok), 32'h1);

        // Two payload words, back-to-back then with gaps
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        applyStimulus(1, 0, 0, 2'b11, 32'h0000_0000, 0);
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_AA51, 0);
        idleCycle();
        checkOutput("two crc_ok", 32'(crc_ok), 32'h1);
        checkOutput("two crc_calc", 32'(crc_calc), 32'hAA51);
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        idleCycle();
        idleCycle();
        applyStimulus(1, 0, 0, 2'b01, 32'h0000_0000, 0);
        idleCycle();
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_AA51, 0);
        idleCycle();
        checkOutput("gaps crc_ok", 32'(crc_ok), 32'h1);
        checkOutput("gaps good_count", 32'(good_count), 32'h5);

        // sof on the second payload word aborts, then the new frame checks
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0005, 0);
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_1021, 0);
        checkOutput("abort framing_err", 32'(framing_err), 32'h1);
        checkOutput("abort crc_err", 32'(crc_err), 32'h1);
        checkOutput("abort bad_count", 32'(bad_count), 32'h2);
        idleCycle();
        checkOutput("after abort crc_ok", 32'(crc_ok), 32'h1);

        // eof while idle
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_0000, 0);
        idleCycle();
        checkOutput("idle eof framing_err", 32'(framing_err), 32'h1);
        checkOutput("idle eof bad_count", 32'(bad_count), 32'h2);

        // Abort combined with a passing empty frame
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0007, 0);
        applyStimulus(1, 1, 1, 2'b11, 32'h0000_0000, 0);
        idleCycle();
        checkOutput("abort+empty crc_ok", 32'(crc_ok), 32'h0);
        checkOutput("abort+empty crc_err", 32'(crc_err), 32'h1);
        checkOutput("abort+empty good_count", 32'(good_count), 32'h7);
        checkOutput("abort+empty bad_count", 32'(bad_count), 32'h3);

        // Abort combined with a failing empty frame: bad_count rises by 2
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0007, 0);
        applyStimulus(1, 1, 1, 2'b11, 32'h0000_0001, 0);
        idleCycle();
        checkOutput("abort+bad bad_count", 32'(bad_count), 32'h5);

        // Saturate bad_count
        for (int i = 0; i < 17; i++) applyStimulus(1, 1, 1, 2'b11, 32'h0000_0001, 0);
        idleCycle();
        checkOutput("sat bad_count", 32'(bad_count), 32'hF);

        // Clear together with a good trailer
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_1021, 1);
        idleCycle();
        checkOutput("clear good_count", 32'(good_count), 32'h0);
        checkOutput("clear bad_count", 32'(bad_count), 32'h0);
        checkOutput("clear crc_ok", 32'(crc_ok), 32'h1);

        // Reset in the middle of a frame
        applyStimulus(1, 1, 1, 2'b11, 32'h0000_0000, 0);
        applyStimulus(1, 1, 0, 2'b11, 32'h1234_5678, 0);
        applyStimulus(1, 0, 0, 2'b11, 32'hDEAD_BEEF, 0);
        idleCycle();
        reset_n = 1'b0;
        #1;
        checkOutput("midreset good_count", 32'(good_count), 32'h0);
        checkOutput("midreset crc_calc", 32'(crc_calc), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1, 1, 0, 2'b11, 32'h0000_0001, 0);
        applyStimulus(1, 0, 0, 2'b11, 32'h0000_0000, 0);
        applyStimulus(1, 0, 1, 2'b11, 32'h0000_AA51, 0);
        idleCycle();
        checkOutput("post reset crc_ok", 32'(crc_ok), 32'h1);
        checkOutput("post reset good_count", 32'(good_count), 32'h1);
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pflink_crc16_checker.md
# pflink_crc16_checker

Receive-side CRC checker for the pflink word stream. It consumes 32-bit frames whose last word carries the CRC-16 appended by the transmit-side generator, and recomputes the CRC over the payload with the same polynomial, bit order and halfword lane masking. It reports a per-frame pass/fail pulse, detects framing violations, and keeps saturating good/bad frame counters for slow-control readout.

## Interface
- `INIT_CRC`, 16'h0000: seed CRC loaded at start of frame; must match the transmitter seed.
- `CNT_W`, 16: width of the good and bad frame counters.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock domain.
- `reset_n` in 1: **asynchronous, active-low reset**.
- `data` in 32: stream word.
- `valid` in 1: word present this cycle; all other stream inputs are ignored when low.
- `we` in 2: halfword lane enables for payload words; a disabled lane contributes zeros. Bit 0 covers [15:0], bit 1 covers [31:16].
- `sof` in 1: first word of a frame.
- `eof` in 1: trailer word; CRC is in `data[15:0]`.
- `clear_counters` in 1: synchronous clear of both counters.
- `crc_ok` out 1: one-cycle pulse, frame passed.
- `crc_err` out 1: one-cycle pulse, frame failed or was aborted.
- `framing_err` out 1: one-cycle pulse, protocol violation.
- `crc_calc` out 16: CRC captured at the last checked trailer.
- `good_count` out CNT_W: saturating count of passed frames.
- `bad_count` out CNT_W: saturating count of failed or aborted frames.

## Operation
- **CRC engine**
  - Polynomial x^16+x^12+x^5+1. The first serial bit is `data[31]`, one 32-bit word per accepted cycle.
  - The masked word is `{we[1]?data[31:16]:0, we[0]?data[15:0]:0}`.
  - Every accepted payload word advances the CRC, including words with `we=2'b00`.
- **States**
  - **IDLE**
    - `valid&sof&~eof`: the word is the first payload word. The CRC engine is seeded with `INIT_CRC`; go to PAYLOAD.
    - `valid&sof&eof`: empty payload. The trailer is compared against `INIT_CRC`; stay in IDLE.
    - `valid&~sof`: `framing_err` pulse, word dropped, counters unchanged.
  - **PAYLOAD**
    - `valid&~sof&~eof`: update the CRC.
    - `valid&eof&~sof`: trailer. Compare `data[15:0]` with the running CRC; return to IDLE. The trailer `we` is ignored and the trailer is not folded into the CRC.
    - `valid&sof` (with or without `eof`): abort. Pulse `framing_err` and `crc_err` and increment `bad_count`. The word is then processed as in IDLE, so the new frame starts this cycle.
- **Check result**
  - Match: `crc_ok`, `good_count`+1.
  - Mismatch: `crc_err`, `bad_count`+1.
  - `crc_calc` is loaded with the compared CRC value.
- **Counters**
  - Saturate at all-ones.
  - `clear_counters` zeroes both counters and takes priority over any increment in the same cycle.
  - An abort and the new frame's empty-payload check in the same cycle both count; `bad_count` can therefore rise by 2 in one cycle.

## Timing
- **Reset values:** every output is 0, the state is IDLE and the running CRC is `INIT_CRC`.
- **Reset mid-frame:** drops the frame with no pulse.
- **Latency:** result pulses and the `crc_calc`/counter updates appear 1 cycle after the trailer is accepted, all registered together. A `framing_err` pulse is registered 1 cycle after the offending word.
- **Pulse overlap:** `crc_ok` and `crc_err` are never high in the same cycle, except the abort-plus-empty-frame case: `crc_err` (abort) may coincide with the result of the new empty frame. In that case the empty frame's pass or fail is still counted, but only the abort drives `crc_err`, and `crc_ok` is suppressed.
- **Throughput and stalls:** no backpressure, one word per cycle. Back-to-back frames with no idle gap are supported. `valid` low holds all state.

## Test plan
- **Empty frame:** reset, then one word `sof=1,eof=1,data=0x00000000` → `crc_ok` 1 cycle later, `good_count=1`, `crc_calc=0x0000`.
- **Single payload word:** payload `0x00000001`, `we=2'b11`, then trailer `0x00001021` → `crc_ok`, `crc_calc=0x1021`. Repeat with trailer `0x00001020` → `crc_err`, `bad_count=1`.
- **Lane masking:** payload `0x00000001` with `we=2'b10`, then trailer `0x00000000` → `crc_ok` (lane 0 masked).
- **Two payload words:** `0x00000001`, `0x00000000`, then trailer `0x0000AA51` → `crc_ok`. Insert `valid=0` gaps between the words → same result.
- **Framing violations:**
  - `sof` on the second payload word → `framing_err` and `crc_err`, `bad_count`+1, and the new frame then checks correctly.
  - `eof` in IDLE → `framing_err` only, no counter change.
- **Counters and reset:**
  - Force `bad_count` to saturate (`CNT_W=4`, 17 bad frames) → it stays at 0xF.
  - `clear_counters` asserted together with a good trailer → `good_count=0`.
  - Assert `reset_n` low mid-frame → all outputs 0 immediately; the next frame checks correctly.
